blink_rate_ctrl: RTL and testbench

Runtime source of the 32-bit `divider` word for the variable clock divider in the variable-blink design. Two raw push-buttons are synchronised, debounced as a pair, and turned into rate commands with hold-to-repeat. "Faster" halves the divider, "slower" doubles it, and pressing both restores the power-on value. The output register feeds the divider's `divider` input directly and never leaves the [MIN_DIV, MAX_DIV] range.

---
 rtl/blink_rate_pkg.sv | 47 ++++
 rtl/blink_rate_ctrl_if.sv | 31 +++
 rtl/btn_sync.sv | 39 +++
 rtl/blink_rate_ctrl.sv | 130 +++++++++++++
 tb/tb_blink_rate_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/blink_rate_pkg.sv
// ---------------------------------------------------------------------------
// blink_rate_pkg: FSM states, rate commands and the saturating divider step.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package blink_rate_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    REPEAT   = 2'd3
  } state_e;

  // Encoding matches key = {faster, slower} so a key value casts directly.
  typedef enum logic [1:0] {
    CMD_NONE   = 2'b00,
    CMD_SLOWER = 2'b01,
    CMD_FASTER = 2'b10,
    CMD_RESET  = 2'b11
  } cmd_e;

  function automatic logic [DIV_W-1:0] step_divider(
    input logic [DIV_W-1:0] cur,
    input cmd_e             cmd,
    input logic [DIV_W-1:0] init_div,
    input logic [DIV_W-1:0] min_div,
    input logic [DIV_W-1:0] max_div
  );
    logic [DIV_W-1:0] nxt;
    nxt = cur;
    case (cmd)
      CMD_FASTER: nxt = ((cur >> 1) < min_div) ? min_div : (cur >> 1);
      // Bound is tested before shifting so the shift can never wrap.
      CMD_SLOWER: nxt = (cur > (max_div >> 1)) ? max_div : (cur << 1);
      CMD_RESET:  nxt = init_div;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_rate_ctrl_if.sv
// ---------------------------------------------------------------------------
// blink_rate_if: button inputs and divider outputs of the rate controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface blink_rate_if;
  import blink_rate_pkg::*;

  logic             btn_faster;
  logic             btn_slower;
  logic [DIV_W-1:0] divider;
  logic             changed;

  modport master (
    output btn_faster,
    output btn_slower,
    input  divider,
    input  changed
  );

  modport slave (
    input  btn_faster,
    input  btn_slower,
    output divider,
    output changed
  );

endinterface

`default_nettype wire

// File: rtl/btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync: WIDTH-bit two-flop synchroniser, resets to the button release level.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_sync #(
  parameter int   WIDTH       = 1,
  parameter logic RELEASE_LVL = 1'b0
) (
  input  wire logic             clk_in,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] async_in,
  output logic      [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{RELEASE_LVL}};
      sync_q <= {WIDTH{RELEASE_LVL}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

`default_nettype wire

// File: rtl/blink_rate_ctrl.sv
// ---------------------------------------------------------------------------
// blink_rate_ctrl: debounced faster/slower buttons with hold-to-repeat drive
// a saturating 32-bit divider word.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module blink_rate_ctrl
  import blink_rate_pkg::*;
#(
  parameter logic [DIV_W-1:0] INIT_DIV        = 32'd6_000_000,
  parameter logic [DIV_W-1:0] MIN_DIV         = 32'd1,
  parameter logic [DIV_W-1:0] MAX_DIV         = 32'h8000_0000,
  parameter int unsigned      DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned      HOLD_CYCLES     = 6_000_000,
  parameter int unsigned      REPEAT_CYCLES   = 1_200_000,
  parameter bit               BTN_ACTIVE_LOW  = 1'b1
) (
  input  wire logic   clk_in,
  input  wire logic   rst_n,
  blink_rate_if.slave bus
);

  localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             REL_LVL   = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]       btn_sync_out;
  logic [1:0]       key;
  logic [1:0]       key_prev_q, key_prev_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] divider_q, divider_d;
  logic             changed_q, changed_d;
  logic             fire;
  logic [DIV_W-1:0] step_val;

  btn_sync #(
    .WIDTH       (2),
    .RELEASE_LVL (REL_LVL)
  ) u_btn_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in ({bus.btn_faster, bus.btn_slower}),
    .sync_out (btn_sync_out)
  );

  assign key = btn_sync_out ^ {2{REL_LVL}};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fire       = 1'b0;
    key_prev_d = key;
    // Any key movement restarts debouncing regardless of the current state.
    if (key != key_prev_q) begin
      state_d = (key != 2'b00) ? DEBOUNCE : IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        DEBOUNCE: begin
          if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            fire    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          // Both-pressed parks here with the counter frozen at its last value.
          if (cnt_q == HOLD_LAST) begin
            if (key != CMD_RESET) begin
              state_d = REPEAT;
              cnt_d   = '0;
              fire    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (cnt_q == REP_LAST) begin
            cnt_d = '0;
            fire  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_val  = step_divider(divider_q, cmd_e'(key), INIT_DIV, MIN_DIV, MAX_DIV);
    divider_d = fire ? step_val : divider_q;
    changed_d = fire && (step_val != divider_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_prev_q <= 2'b00;
      divider_q  <= INIT_DIV;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_prev_q <= key_prev_d;
      divider_q  <= divider_d;
      changed_q  <= changed_d;
    end
  end

  assign bus.divider = divider_q;
  assign bus.changed = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_blink_rate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_blink_rate_ctrl: scoreboard bench for blink_rate_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_blink_rate_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   pulse_cnt = 0;
  exp_t exp_q[$];

  blink_rate_if bus();

  blink_rate_ctrl #(
    .INIT_DIV        (32'd16),
    .MIN_DIV         (32'd2),
    .MAX_DIV         (32'd64),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8),
    .BTN_ACTIVE_LOW  (1'b0)
  ) u_dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every changed pulse must match the oldest outstanding expected update.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.changed === 1'b1) begin
      exp_t e;
      pulse_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_update: divider=%0d at cycle %0d, required no update", bus.divider, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.divider !== e.val || cyc !== e.cyc)
          $display("FAIL update: divider=%0d at cycle %0d, required %0d at cycle %0d",
                   bus.divider, cyc, e.val, e.cyc);
        else
          n_pass++;
      end
    end
  end

  task automatic do_reset();
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic press(input logic f, input logic s, input int hold, input logic [31:0] exp_val);
    @(posedge clk);
    #1;
    bus.btn_faster = f;
    bus.btn_slower = s;
    exp_q.push_back('{cyc + 7, exp_val});
    repeat (hold) @(posedge clk);
    #1;
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.divider !== 32'd16) $display("FAIL reset_div: divider=%0d, required 16", bus.divider);
    else n_pass++;
    n_checks++;
    if (bus.changed !== 1'b0) $display("FAIL reset_changed: changed=%b, required 0", bus.changed);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd16) $display("FAIL post_reset_div: divider=%0d, required 16", bus.divider);
    else n_pass++;
    n_checks++;
    if (bus.changed !== 1'b0) $display("FAIL post_reset_changed: changed=%b, required 0", bus.changed);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    int base;
    do_reset();
    base = pulse_cnt;
    @(posedge clk);
    #1;
    bus.btn_faster = 1'b1;
    exp_q.push_back('{cyc + 7, 32'd8});
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd16) $display("FAIL clean_early: divider=%0d, required 16", bus.divider);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd8) $display("FAIL clean_latency: divider=%0d, required 8", bus.divider);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    bus.btn_faster = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (pulse_cnt - base !== 1) $display("FAIL clean_pulses: pulses=%0d, required 1", pulse_cnt - base);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL clean_pending: outstanding=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.btn_slower = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    bus.btn_slower = 1'b1;
    exp_q.push_back('{cyc + 7, 32'd32});
    repeat (12) @(posedge clk);
    #1;
    bus.btn_slower = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd32) $display("FAIL bounce_div: divider=%0d, required 32", bus.divider);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL bounce_pending: outstanding=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_repeat_sat();
    int base;
    do_reset();
    base = pulse_cnt;
    @(posedge clk);
    #1;
    bus.btn_slower = 1'b1;
    exp_q.push_back('{cyc + 7, 32'd32});
    exp_q.push_back('{cyc + 27, 32'd64});
    repeat (80) @(posedge clk);
    #1;
    bus.btn_slower = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd64) $display("FAIL sat_div: divider=%0d, required 64", bus.divider);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - base !== 2) $display("FAIL sat_pulses: pulses=%0d, required 2", pulse_cnt - base);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sat_pending: outstanding=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_both();
    int base;
    do_reset();
    press(1'b1, 1'b0, 10, 32'd8);
    press(1'b1, 1'b0, 10, 32'd4);
    n_checks++;
    if (bus.divider !== 32'd4) $display("FAIL both_setup: divider=%0d, required 4", bus.divider);
    else n_pass++;
    base = pulse_cnt;
    press(1'b1, 1'b1, 100, 32'd16);
    n_checks++;
    if (bus.divider !== 32'd16) $display("FAIL both_div: divider=%0d, required 16", bus.divider);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - base !== 1) $display("FAIL both_pulses: pulses=%0d, required 1", pulse_cnt - base);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL both_pending: outstanding=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int tr;
    do_reset();
    @(posedge clk);
    #1;
    bus.btn_faster = 1'b1;
    exp_q.push_back('{cyc + 7, 32'd8});
    exp_q.push_back('{cyc + 27, 32'd4});
    exp_q.push_back('{cyc + 35, 32'd2});
    repeat (38) @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd2) $display("FAIL mid_min: divider=%0d, required 2", bus.divider);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.divider !== 32'd16 || bus.changed !== 1'b0)
      $display("FAIL mid_reset: divider=%0d changed=%b, required 16 and 0", bus.divider, bus.changed);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tr = cyc;
    exp_q.push_back('{tr + 7, 32'd8});
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd16) $display("FAIL mid_redebounce: divider=%0d, required 16", bus.divider);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.divider !== 32'd8) $display("FAIL mid_latency: divider=%0d, required 8", bus.divider);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    bus.btn_faster = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL mid_pending: outstanding=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat_sat();
    test_both();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
